srt_otf_conv: RTL and testbench

- Radix-4 SRT on-the-fly quotient converter. It is the consumer of the per-iteration signed quotient digits produced by the qds digit-selection block.
- Accumulates NDIG redundant digits in {-2..+2} into a two's-complement quotient, using the Q/QM register pair, so no carry-propagate adder is needed.
- Applies the final -1 correction when the divider's last partial remainder is negative.
- Sits between the SRT iteration datapath and the divider's result register.

---
 rtl/srt_pkg.sv | 28 ++
 rtl/srt_otf_step.sv | 45 ++++
 rtl/srt_otf_conv.sv | 129 ++++++++++++
 tb/tb_srt_otf_conv.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/srt_pkg.sv
// Shared types for the radix-4 SRT divider: quotient digit encoding and
// the on-the-fly converter state set.
package srt_pkg;

   typedef logic [2:0] qdigit_t;

   localparam qdigit_t QD_ZERO = 3'b000;
   localparam qdigit_t QD_P1   = 3'b001;
   localparam qdigit_t QD_P2   = 3'b010;
   localparam qdigit_t QD_M1   = 3'b111;
   localparam qdigit_t QD_M2   = 3'b110;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      FINAL = 2'd2,
      DONE  = 2'd3
   } otf_state_t;

   // True for the five codes in {-2..+2}; 011/100/101 are illegal.
   function automatic logic qd_legal(input qdigit_t d);
      case (d)
         QD_ZERO, QD_P1, QD_P2, QD_M1, QD_M2: qd_legal = 1'b1;
         default:                             qd_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/srt_otf_step.sv
// One radix-4 on-the-fly conversion step: next Q/QM for a single signed digit.
// Purely combinational so two can be chained for a radix-16 variant.
module srt_otf_step
   import srt_pkg::*;
#(
   parameter int unsigned QW = 32
)
(
   input  logic [QW-1:0] q,
   input  logic [QW-1:0] qm,
   input  logic [2:0]    digit,
   output logic [QW-1:0] q_nxt_c,
   output logic [QW-1:0] qm_nxt_c,
   output logic          illegal_c
);

   logic [QW-1:0] q_sh;
   logic [QW-1:0] qm_sh;
   qdigit_t       d;
   logic [1:0]    lo;
   logic [1:0]    lo_m1;

   always_comb begin
      d         = digit;
      q_sh      = q << 2;
      qm_sh     = qm << 2;
      lo        = d[1:0];
      lo_m1     = 2'(lo - 2'd1);
      illegal_c = !qd_legal(d);
      // Zero (and illegal, treated as zero): Q appends 00, QM appends 11.
      q_nxt_c   = q_sh;
      qm_nxt_c  = qm_sh | QW'(2'b11);
      if (!illegal_c && (d != QD_ZERO)) begin
         // For negative digits 4+d and 3+d reduce mod 4 to lo and lo-1.
         if (d[2]) begin
            q_nxt_c  = qm_sh | QW'(lo);
            qm_nxt_c = qm_sh | QW'(lo_m1);
         end else begin
            q_nxt_c  = q_sh | QW'(lo);
            qm_nxt_c = q_sh | QW'(lo_m1);
         end
      end
   end

endmodule

// File: rtl/srt_otf_conv.sv
// Radix-4 SRT on-the-fly quotient converter: accumulates NDIG signed digits
// into Q/QM, applies the negative-remainder correction, hands off the result.
module srt_otf_conv
   import srt_pkg::*;
#(
   parameter int unsigned NDIG = 16
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                digit_valid,
   output logic                digit_ready,
   input  logic [2:0]          digit,
   input  logic                rem_valid,
   input  logic                rem_neg,
   output logic                q_valid,
   input  logic                q_ready,
   output logic [2*NDIG-1:0]   quotient,
   output logic                busy,
   output logic                err
);

   localparam int unsigned QW = 2 * NDIG;
   localparam int unsigned CW = (NDIG > 1) ? $clog2(NDIG) : 1;

   localparam logic [1:0] ST_IDLE  = 2'(IDLE);
   localparam logic [1:0] ST_ACCUM = 2'(ACCUM);
   localparam logic [1:0] ST_FINAL = 2'(FINAL);
   localparam logic [1:0] ST_DONE  = 2'(DONE);

   logic [1:0]    state, state_nxt;
   logic [QW-1:0] q, q_nxt;
   logic [QW-1:0] qm, qm_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          err_nxt;
   logic          q_valid_nxt;
   logic [QW-1:0] quotient_nxt;

   logic [QW-1:0] step_q_c;
   logic [QW-1:0] step_qm_c;
   logic          step_illegal_c;

   srt_otf_step #(.QW(QW)) u_step (
      .q         (q),
      .qm        (qm),
      .digit     (digit),
      .q_nxt_c   (step_q_c),
      .qm_nxt_c  (step_qm_c),
      .illegal_c (step_illegal_c)
   );

   // State and datapath registers; status outputs decode the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         q           <= '0;
         qm          <= '1;
         cnt         <= '0;
         err         <= 1'b0;
         q_valid     <= 1'b0;
         quotient    <= '0;
         digit_ready <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nxt;
         q           <= q_nxt;
         qm          <= qm_nxt;
         cnt         <= cnt_nxt;
         err         <= err_nxt;
         q_valid     <= q_valid_nxt;
         quotient    <= quotient_nxt;
         digit_ready <= (state_nxt == ST_ACCUM);
         busy        <= (state_nxt != ST_IDLE);
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_nxt    = state;
      q_nxt        = q;
      qm_nxt       = qm;
      cnt_nxt      = cnt;
      err_nxt      = err;
      q_valid_nxt  = q_valid;
      quotient_nxt = quotient;
      case (state)
         ST_IDLE: begin
            if (start) begin
               q_nxt     = '0;
               qm_nxt    = '1;
               cnt_nxt   = '0;
               err_nxt   = 1'b0;
               state_nxt = ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            if (digit_valid) begin
               q_nxt   = step_q_c;
               qm_nxt  = step_qm_c;
               cnt_nxt = cnt + CW'(1);
               if (step_illegal_c) begin
                  err_nxt = 1'b1;
               end
               if (cnt == CW'(NDIG - 1)) begin
                  state_nxt = ST_FINAL;
               end
            end
         end
         ST_FINAL: begin
            if (rem_valid) begin
               quotient_nxt = rem_neg ? qm : q;
               q_valid_nxt  = 1'b1;
               state_nxt    = ST_DONE;
            end
         end
         ST_DONE: begin
            if (q_ready) begin
               q_valid_nxt = 1'b0;
               state_nxt   = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_srt_otf_conv.sv
// Self-checking bench for srt_otf_conv (NDIG=4, QW=8): fixed vectors,
// hand-written handshake/reset sequences and random digit streams.
module tb_srt_otf_conv;

   localparam int unsigned NDIG = 4;
   localparam int unsigned QW   = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          digit_valid = 1'b0;
   logic          digit_ready;
   logic [2:0]    digit = 3'b000;
   logic          rem_valid = 1'b0;
   logic          rem_neg = 1'b0;
   logic          q_valid;
   logic          q_ready = 1'b0;
   logic [QW-1:0] quotient;
   logic          busy;
   logic          err;

   int n_assert = 0;
   int n_fail   = 0;

   srt_otf_conv #(.NDIG(NDIG)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .digit_valid (digit_valid),
      .digit_ready (digit_ready),
      .digit       (digit),
      .rem_valid   (rem_valid),
      .rem_neg     (rem_neg),
      .q_valid     (q_valid),
      .q_ready     (q_ready),
      .quotient    (quotient),
      .busy        (busy),
      .err         (err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference: quotient is the signed radix-4 digit sum, minus one when the remainder is negative.
   function automatic int dval(input logic [2:0] c);
      case (c)
         3'b001:  return 1;
         3'b010:  return 2;
         3'b111:  return -1;
         3'b110:  return -2;
         default: return 0;
      endcase
   endfunction

   function automatic logic [QW-1:0] model_q(input logic [3*NDIG-1:0] dp, input logic rn);
      int v = 0;
      for (int i = 0; i < NDIG; i++) v = v * 4 + dval(dp[3*i +: 3]);
      v = v - (rn ? 1 : 0);
      return QW'(v);
   endfunction

   function automatic logic model_err(input logic [3*NDIG-1:0] dp);
      logic e = 1'b0;
      for (int i = 0; i < NDIG; i++) begin
         if (dp[3*i +: 3] inside {3'b011, 3'b100, 3'b101}) e = 1'b1;
      end
      return e;
   endfunction

   // Full division; digit i (i=0 first, most significant) is dp[3*i +: 3].
   task automatic do_div(input logic [3*NDIG-1:0] dp, input logic rn, input int gap_max,
                         output logic [QW-1:0] q_out, output logic e_out);
      int waitc;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < NDIG; i++) begin
         digit_valid = 1'b0;
         repeat ($urandom_range(gap_max, 0)) @(negedge clk);
         digit       = dp[3*i +: 3];
         digit_valid = 1'b1;
         waitc = 0;
         while (!digit_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
         end
         if (!digit_ready) check("digit_ready_timeout", 32'(digit_ready), 32'd1);
         @(negedge clk);
      end
      digit_valid = 1'b0;
      check("final_digit_ready", 32'(digit_ready), 32'd0);
      check("pre_q_valid", 32'(q_valid), 32'd0);
      rem_valid = 1'b1;
      rem_neg   = rn;
      @(negedge clk);
      rem_valid = 1'b0;
      check("q_valid_latency", 32'(q_valid), 32'd1);
      q_out   = quotient;
      e_out   = err;
      q_ready = 1'b1;
      @(negedge clk);
      q_ready = 1'b0;
      check("idle_after_handshake", {30'd0, busy, q_valid}, 32'd0);
   endtask

   typedef struct {
      logic [3*NDIG-1:0] dp;
      logic              rn;
      logic [QW-1:0]     exp_q;
      logic              exp_err;
   } vec_t;

   vec_t           vecs[4];
   logic [2:0]     legal[5];
   logic [2:0]     illegal[3];
   logic [QW-1:0]  got_q;
   logic           got_e;
   logic [3*NDIG-1:0] rdp;
   logic           rrn;

   initial begin
      vecs[0] = '{dp: {3'b001, 3'b000, 3'b111, 3'b010}, rn: 1'b0, exp_q: 8'h71, exp_err: 1'b0};
      vecs[1] = '{dp: {3'b001, 3'b000, 3'b111, 3'b010}, rn: 1'b1, exp_q: 8'h70, exp_err: 1'b0};
      vecs[2] = '{dp: {3'b001, 3'b110, 3'b111, 3'b000}, rn: 1'b1, exp_q: 8'hE8, exp_err: 1'b0};
      vecs[3] = '{dp: {3'b000, 3'b000, 3'b100, 3'b000}, rn: 1'b0, exp_q: 8'h00, exp_err: 1'b1};
      legal   = '{3'b000, 3'b001, 3'b010, 3'b111, 3'b110};
      illegal = '{3'b011, 3'b100, 3'b101};

      // Reset state
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("reset_outputs", {23'd0, digit_ready, q_valid, busy, err, quotient}, 32'd0);

      // Fixed vectors
      for (int i = 0; i < 4; i++) begin
         do_div(vecs[i].dp, vecs[i].rn, 0, got_q, got_e);
         check($sformatf("vec%0d_quotient", i), 32'(got_q), 32'(vecs[i].exp_q));
         check($sformatf("vec%0d_err", i), 32'(got_e), 32'(vecs[i].exp_err));
      end

      // A new start clears the sticky error left by vector 3
      check("err_held_in_idle", 32'(err), 32'd1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("err_cleared_by_start", 32'(err), 32'd0);
      check("accum_after_start", {30'd0, busy, digit_ready}, 32'd3);

      // Reset mid-ACCUM after two digits
      digit = 3'b010; digit_valid = 1'b1;
      repeat (2) @(negedge clk);
      digit_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_abort_outputs", {29'd0, busy, digit_ready, q_valid}, 32'd0);
      do_div(vecs[0].dp, 1'b0, 0, got_q, got_e);
      check("after_abort_quotient", 32'(got_q), 32'h71);
      check("after_abort_err", 32'(got_e), 32'd0);

      // Gaps, early rem_valid, backpressure, start during DONE
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      digit = 3'b010; digit_valid = 1'b1;
      @(negedge clk);
      digit_valid = 1'b0;
      rem_valid = 1'b1; rem_neg = 1'b1;
      @(negedge clk);
      rem_valid = 1'b0; rem_neg = 1'b0;
      check("early_rem_ignored", {30'd0, digit_ready, q_valid}, 32'd2);
      digit = 3'b111; digit_valid = 1'b1;
      @(negedge clk);
      digit_valid = 1'b0;
      repeat (2) @(negedge clk);
      digit = 3'b000; digit_valid = 1'b1;
      @(negedge clk);
      digit_valid = 1'b0;
      @(negedge clk);
      digit = 3'b001; digit_valid = 1'b1;
      @(negedge clk);
      digit_valid = 1'b0;
      check("in_final", {30'd0, digit_ready, busy}, 32'd1);
      rem_valid = 1'b1; rem_neg = 1'b0;
      @(negedge clk);
      rem_valid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         start = (c == 2);
         check($sformatf("backpressure%0d", c), {23'd0, q_valid, quotient}, {23'd0, 1'b1, 8'h71});
         @(negedge clk);
      end
      start   = 1'b1;
      q_ready = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      q_ready = 1'b0;
      check("handshake_start_ignored", {30'd0, busy, q_valid}, 32'd0);
      @(negedge clk);
      check("still_idle", {30'd0, busy, digit_ready}, 32'd0);
      check("quotient_held_idle", 32'(quotient), 32'h71);

      // Random digit streams against the arithmetic model
      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < NDIG; i++) begin
            int r = $urandom_range(10, 0);
            rdp[3*i +: 3] = (r < 10) ? legal[r % 5] : illegal[$urandom_range(2, 0)];
         end
         rrn = 1'($urandom_range(1, 0));
         do_div(rdp, rrn, 2, got_q, got_e);
         check($sformatf("rand%0d_quotient dp=%h rn=%0d", n, rdp, rrn), 32'(got_q), 32'(model_q(rdp, rrn)));
         check($sformatf("rand%0d_err", n), 32'(got_e), 32'(model_err(rdp)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
